// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared register map, mode encodings and control bit index
package led_seq_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int EN_BIT = 2;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - Avalon-MM register bus between CPU and sequencer
interface led_pattern_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/led_tick_prescaler.sv
// rtl/led_tick_prescaler.sv - down-counter producing one step pulse every load_val+1 enabled cycles
module led_tick_prescaler #(
  parameter int CNT_W     = 24,
  parameter int RESET_VAL = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             step
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A bus load in the terminal cycle swallows that step.
  assign step = en && !load && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? load_val : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_W'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - LED PIO replacement that animates out_port from a CPU-written pattern
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH        = 18,
  parameter int CNT_W        = 24,
  parameter int PERIOD_RESET = 5000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  led_pattern_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]        out_port
);

  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [15:0]      step_count_q, step_count_d;
  logic [WIDTH-1:0] out_port_q, out_port_d;

  logic             wr, wr_data, wr_ctrl, wr_period;
  logic             step;
  logic [CNT_W-1:0] load_val;
  mode_e            mode, mode_next;
  wire              unused_wdata = ^bus.writedata;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_data   = wr && (bus.address == ADDR_DATA);
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign wr_period = wr && (bus.address == ADDR_PERIOD);
  assign load_val  = wr_period ? bus.writedata[CNT_W-1:0] : period_q;
  assign mode      = mode_e'(ctrl_q[1:0]);

  led_tick_prescaler #(
    .CNT_W     (CNT_W),
    .RESET_VAL (PERIOD_RESET)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ctrl_q[EN_BIT]),
    .load     (wr_data || wr_ctrl || wr_period),
    .load_val (load_val),
    .step     (step)
  );

  always_comb begin
    pattern_d    = pattern_q;
    work_d       = work_q;
    ctrl_d       = ctrl_q;
    period_d     = period_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    step_count_d = step_count_q;
    if (wr_data) begin
      pattern_d    = bus.writedata[WIDTH-1:0];
      work_d       = bus.writedata[WIDTH-1:0];
      phase_d      = 1'b1;
      dir_d        = 1'b0;
      step_count_d = '0;
    end else if (wr_ctrl) begin
      ctrl_d  = bus.writedata[2:0];
      phase_d = 1'b1;
    end else if (wr_period) begin
      period_d = bus.writedata[CNT_W-1:0];
    end else if (step) begin
      step_count_d = step_count_q + 16'd1;
      case (mode)
        MODE_BLINK:  phase_d = ~phase_q;
        MODE_ROTATE: work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        MODE_BOUNCE: begin
          // Reverse at the end bit and move one place back the other way in the same step.
          if (!dir_q) begin
            if (work_q[WIDTH-1]) begin
              dir_d  = 1'b1;
              work_d = work_q >> 1;
            end else begin
              work_d = work_q << 1;
            end
          end else begin
            if (work_q[0]) begin
              dir_d  = 1'b0;
              work_d = work_q << 1;
            end else begin
              work_d = work_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
    mode_next  = mode_e'(ctrl_d[1:0]);
    out_port_d = (mode_next == MODE_BLINK && !phase_d) ? '0 : work_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q    <= '0;
      work_q       <= '0;
      ctrl_q       <= '0;
      period_q     <= CNT_W'(PERIOD_RESET);
      phase_q      <= 1'b1;
      dir_q        <= 1'b0;
      step_count_q <= '0;
      out_port_q   <= '0;
    end else begin
      pattern_q    <= pattern_d;
      work_q       <= work_d;
      ctrl_q       <= ctrl_d;
      period_q     <= period_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      step_count_q <= step_count_d;
      out_port_q   <= out_port_d;
    end
  end

  assign out_port = out_port_q;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata = 32'(pattern_q);
      ADDR_CTRL:   bus.readdata = {29'd0, ctrl_q};
      ADDR_PERIOD: bus.readdata = 32'(period_q);
      ADDR_STATUS: bus.readdata = {14'd0, dir_q, phase_q, step_count_q};
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] out_port;
  int          total = 0;
  int          bad = 0;

  logic [63:0] sb_q[$];
  logic [17:0] m_work = '0;
  logic        m_phase = 1'b1;
  logic        m_dir = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [2:0]  m_ctrl = '0;
  int          m_period = 5000000;
  logic [31:0] rd;

  led_pattern_sequencer_if bus_if ();

  led_pattern_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_out();
    return (m_ctrl[1:0] == 2'd1 && !m_phase) ? 32'd0 : {14'd0, m_work};
  endfunction

  function automatic logic [31:0] model_status();
    return {14'd0, m_dir, m_phase, m_cnt};
  endfunction

  task automatic model_step();
    m_cnt = m_cnt + 16'd1;
    case (m_ctrl[1:0])
      2'd1: m_phase = !m_phase;
      2'd2: m_work = (m_work << 1) | (m_work >> 17);
      2'd3: begin
        if (!m_dir && m_work[17])      begin m_dir = 1'b1; m_work = m_work >> 1; end
        else if (!m_dir)               m_work = m_work << 1;
        else if (m_work[0])            begin m_dir = 1'b0; m_work = m_work << 1; end
        else                           m_work = m_work >> 1;
      end
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    data = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic wr_data(input logic [17:0] d);
    bus_write(2'd0, {14'd0, d});
    m_work = d; m_phase = 1'b1; m_dir = 1'b0; m_cnt = '0;
  endtask

  task automatic wr_ctrl(input logic [2:0] c);
    bus_write(2'd1, {29'd0, c});
    m_ctrl = c; m_phase = 1'b1;
  endtask

  task automatic wr_period(input int p);
    bus_write(2'd2, p);
    m_period = p;
  endtask

  task automatic cfg(input logic [17:0] d, input int p, input logic [2:0] c);
    wr_ctrl(3'd0);
    wr_data(d);
    wr_period(p);
    wr_ctrl(c);
  endtask

  // Each step: push the predicted output/status, wait period+1 edges, pop and compare.
  task automatic run_steps(input int n);
    logic [63:0] e;
    logic [31:0] prev;
    for (int i = 0; i < n; i++) begin
      prev = model_out();
      model_step();
      sb_q.push_back({model_status(), model_out()});
      if (m_period > 0) begin
        repeat (m_period) @(posedge clk);
        #1 check("hold_before_step", {14'd0, out_port}, prev);
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("step_out", {14'd0, out_port}, e[31:0]);
      bus_read(2'd3, rd);
      check("step_status", rd, e[63:32]);
    end
  endtask

  initial begin
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;

    check("rst_out", {14'd0, out_port}, 32'd0);
    bus_read(2'd0, rd); check("rst_data", rd, 32'd0);
    bus_read(2'd1, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_period", rd, 32'd5000000);
    bus_read(2'd3, rd); check("rst_status", rd, 32'h10000);

    cfg(18'h00001, 3, 3'b110);
    bus_read(2'd2, rd); check("period_rb", rd, 32'd3);
    run_steps(18);
    check("rot_wrap_out", {14'd0, out_port}, 32'h00001);
    bus_read(2'd3, rd); check("rot_count", {16'd0, rd[15:0]}, 32'd18);

    cfg(18'h20000, 0, 3'b111);
    run_steps(1);
    check("bnc_first", {14'd0, out_port}, 32'h10000);
    bus_read(2'd3, rd); check("bnc_dir1", {31'd0, rd[17]}, 32'd1);
    run_steps(16);
    check("bnc_17", {14'd0, out_port}, 32'h00001);
    run_steps(1);
    check("bnc_18", {14'd0, out_port}, 32'h00002);
    bus_read(2'd3, rd); check("bnc_dir0", {31'd0, rd[17]}, 32'd0);
    bus_read(2'd0, rd); check("data_is_pattern", rd, 32'h20000);

    cfg(18'h3FFFF, 1, 3'b101);
    run_steps(6);
    wr_ctrl(3'b001);
    check("blink_freeze", {14'd0, out_port}, 32'h3FFFF);
    repeat (20) @(posedge clk);
    #1 check("blink_frozen_out", {14'd0, out_port}, 32'h3FFFF);
    bus_read(2'd3, rd); check("blink_frozen_status", rd, model_status());

    cfg(18'h00001, 3, 3'b110);
    run_steps(2);
    repeat (3) @(posedge clk);
    wr_data(18'h00F00);
    check("collide_out", {14'd0, out_port}, 32'h00F00);
    bus_read(2'd3, rd); check("collide_status", rd, 32'h10000);
    run_steps(1);
    check("collide_next", {14'd0, out_port}, 32'h01E00);

    cfg(18'h00100, 0, 3'b111);
    run_steps(3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst_out", {14'd0, out_port}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_work = '0; m_phase = 1'b1; m_dir = 1'b0; m_cnt = '0; m_ctrl = '0; m_period = 5000000;
    #1;
    bus_read(2'd2, rd); check("post_rst_period", rd, 32'd5000000);
    bus_read(2'd0, rd); check("post_rst_data", rd, 32'd0);
    bus_read(2'd1, rd); check("post_rst_ctrl", rd, 32'd0);
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(2'd3, rd); check("status_ro", rd, 32'h10000);
    repeat (5) @(posedge clk);
    #1 check("post_rst_out", {14'd0, out_port}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
